// File: rtl/vga_fill_pkg.sv
// Shared types and default geometry for the vga text filler.
//   mode_e  : command modes carried on cmd_mode
//   state_e : filler FSM states
//   Def*    : default screen geometry and glyph width
package vga_fill_pkg;

  localparam int unsigned DefCols  = 80;
  localparam int unsigned DefRows  = 24;
  localparam int unsigned DefCharW = 8;

  typedef enum logic [1:0] {
    ModeClear = 2'd0,
    ModeFill  = 2'd1,
    ModeRamp  = 2'd2,
    ModeCycle = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/vga_fill_pacer.sv
// Write pacer: after each restart, tick_o rises once TICK_DIV-1 further clocks have
// elapsed, so consecutive cell writes land TICK_DIV clocks apart.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   restart_i : pulse in the cycle a cell is written
//   tick_o    : next cell may be written at the coming edge
module vga_fill_pacer #(
  parameter int unsigned TICK_DIV = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The write cycle itself counts as the first clock of the interval.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CntW'(1);
    end else if (cnt_q < CntLast) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q >= CntLast);

endmodule

// File: rtl/vga_text_filler.sv
// Command-driven writer into the vga text core character buffer. Walks every cell of a
// COLS x ROWS screen, one strobe per cell, in CLEAR / FILL / RAMP / CYCLE mode.
//   CLK, RST_N        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake; cmd_mode, cmd_char latched on acceptance
//   stop              : abort at the next cell boundary
//   write_char/_pos/_strobe : registered write port to the vga core
//   busy              : command in progress
//   done              : one-cycle pulse on completion or abort
// Build option: VGA_TEXT_FILLER_PACE_EN enables the TICK_DIV pacer; otherwise one cell is
// written every two clocks.
module vga_text_filler
  import vga_fill_pkg::*;
#(
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned CHAR_W     = DefCharW,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned NUM_GLYPHS = 5,
  parameter int unsigned TICK_DIV   = 20000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [CHAR_W-1:0] cmd_char,
  input  logic              stop,
  output logic [CHAR_W-1:0] write_char,
  output logic [ADDR_W-1:0] write_char_pos,
  output logic              write_char_strobe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(CELLS - 1);
  localparam logic [CHAR_W-1:0] LastGlyph = CHAR_W'(NUM_GLYPHS - 1);

  state_e            state_q;
  mode_e             mode_q;
  logic [CHAR_W-1:0] fill_q;
  logic [CHAR_W-1:0] ramp_q;
  logic [CHAR_W-1:0] glyph_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              strobe_q;
  logic [CHAR_W-1:0] char_q;
  logic [ADDR_W-1:0] pos_q;

  logic              tick;
  logic              last_cell;
  logic [CHAR_W-1:0] cell_char;
  logic [CHAR_W-1:0] start_glyph;

`ifdef VGA_TEXT_FILLER_PACE_EN
  logic restart;

  assign restart = (state_q == StRun);

  vga_fill_pacer #(
    .TICK_DIV(TICK_DIV)
  ) u_pacer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .restart_i(restart),
    .tick_o   (tick)
  );
`else
  // Unpaced: WAIT always lasts exactly one cycle. TICK_DIV is >= 1, so this is constant 1.
  assign tick = (TICK_DIV != 0);
`endif

  assign last_cell   = (addr_q == LastAddr);
  assign start_glyph = CHAR_W'(32'(cmd_char) % NUM_GLYPHS);

  always_comb begin
    cell_char = '0;
    unique case (mode_q)
      ModeClear: cell_char = '0;
      ModeFill:  cell_char = fill_q;
      ModeRamp:  cell_char = ramp_q;
      ModeCycle: cell_char = glyph_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      mode_q   <= ModeClear;
      fill_q   <= '0;
      ramp_q   <= '0;
      glyph_q  <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      char_q   <= '0;
      pos_q    <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && ready_q) begin
            mode_q  <= mode_e'(cmd_mode);
            fill_q  <= cmd_char;
            glyph_q <= start_glyph;
            ramp_q  <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          strobe_q <= 1'b1;
          pos_q    <= addr_q;
          char_q   <= cell_char;
          addr_q   <= last_cell ? '0 : addr_q + 1'b1;
          // Ramp glyph tracks addr mod NUM_GLYPHS without a divider.
          ramp_q   <= (ramp_q == LastGlyph) ? '0 : ramp_q + 1'b1;
          if (last_cell) begin
            glyph_q <= (glyph_q == LastGlyph) ? '0 : glyph_q + 1'b1;
          end
          if (stop || (last_cell && (mode_q != ModeCycle))) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else if (tick) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready         = ready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign write_char_strobe = strobe_q;
  assign write_char        = char_q;
  assign write_char_pos    = pos_q;

endmodule

// File: tb/tb_vga_text_filler.sv
module tb_vga_text_filler;

  localparam int COLS  = 8;
  localparam int ROWS  = 2;
  localparam int CELLS = COLS * ROWS;
  localparam int NG    = 5;
  localparam int TDIV  = 4;
`ifdef VGA_TEXT_FILLER_PACE_EN
  localparam int P = (TDIV > 1) ? TDIV : 2;
`else
  localparam int P = 2;
`endif
  localparam int INF = 32'h7fff_ffff;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_char = 8'd0;
  logic       stop = 1'b0;
  logic [7:0] write_char;
  logic [3:0] write_char_pos;
  logic       write_char_strobe;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  bit         hold_en = 1'b0;
  logic [1:0] hold_mode = 2'd0;
  logic [7:0] hold_char = 8'd0;

  vga_text_filler #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CHAR_W    (8),
    .ADDR_W    (4),
    .NUM_GLYPHS(NG),
    .TICK_DIV  (TDIV)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mode         (cmd_mode),
    .cmd_char         (cmd_char),
    .stop             (stop),
    .write_char       (write_char),
    .write_char_pos   (write_char_pos),
    .write_char_strobe(write_char_strobe),
    .busy             (busy),
    .done             (done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: glyph of the idx-th write of a command, straight from the mode rules.
  function automatic int ref_char(input logic [1:0] m, input int c, input int idx);
    case (m)
      2'd0:    return 0;
      2'd1:    return c;
      2'd2:    return (idx % CELLS) % NG;
      default: return ((c % NG) + idx / CELLS) % NG;
    endcase
  endfunction

  // Issue one command and check every cycle until its done pulse. stop_n>0 raises stop on
  // the edge of the stop_n-th write (ph 0), the edge after it (ph 1) or the last wait edge
  // before the next write (ph 2).
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] c, input int stop_n,
                         input int stop_ph, input bit chained, output int n_seen,
                         output int lpos, output int lchar, output int done_t);
    int t_nat, t_stop, t_fin, waits, off, idx, exp_pos, exp_ch;
    bit exp_stb;
    n_seen = 0; lpos = -1; lchar = -1; done_t = -1;
    off    = (stop_ph == 0) ? 0 : (stop_ph == 1) ? 1 : P - 1;
    t_nat  = (m == 2'd3) ? INF : 1 + (CELLS - 1) * P;
    t_stop = (stop_n > 0) ? 1 + (stop_n - 1) * P + off : INF;
    t_fin  = (t_stop < t_nat) ? t_stop : t_nat;
    cmd_mode = m; cmd_char = c; cmd_valid = 1'b1;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 100) begin
      @(posedge CLK); #1; waits++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("accept timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (chained) chk("chained accept delay", waits, 0);
    @(posedge CLK); #1;
    if (hold_en) begin
      cmd_mode = hold_mode; cmd_char = hold_char;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("accept busy", busy, 1);
    chk("accept ready", cmd_ready, 0);
    chk("accept strobe", write_char_strobe, 0);
    chk("accept done", done, 0);
    exp_pos = 0; exp_ch = 0;
    for (int t = 1; t <= t_fin + 1; t++) begin
      stop = (t == t_stop);
      @(posedge CLK); #1;
      exp_stb = (t <= t_fin) && ((t - 1) % P == 0);
      chk($sformatf("strobe t=%0d", t), write_char_strobe, exp_stb);
      if (exp_stb) begin
        idx     = (t - 1) / P;
        exp_pos = idx % CELLS;
        exp_ch  = ref_char(m, c, idx);
      end
      chk($sformatf("pos t=%0d", t), write_char_pos, exp_pos);
      chk($sformatf("char t=%0d", t), write_char, exp_ch);
      chk($sformatf("busy t=%0d", t), busy, (t < t_fin));
      chk($sformatf("done t=%0d", t), done, (t == t_fin + 1));
      chk($sformatf("ready t=%0d", t), cmd_ready, (t == t_fin + 1));
      if (write_char_strobe === 1'b1) begin
        n_seen++; lpos = write_char_pos; lchar = write_char;
      end
      if (done === 1'b1) done_t = t;
    end
    stop = 1'b0;
    chk("strobe count", n_seen, ((t_fin - 1) / P) + 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] chr;
    int         stop_n;
    int         stop_ph;
    int         exp_n;
    int         exp_pos;
    int         exp_char;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, lp, lc, dt, found;
    logic [1:0] rm;
    logic [7:0] rc;
    int rs, rp;

    vecs[0] = '{2'd1, 8'h41, 0,  0, 16, 15, 8'h41};
    vecs[1] = '{2'd2, 8'hab, 0,  0, 16, 15, 0};
    vecs[2] = '{2'd0, 8'h7f, 0,  0, 16, 15, 0};
    vecs[3] = '{2'd3, 8'h03, 40, 1, 40, 7,  0};
    vecs[4] = '{2'd3, 8'h09, 20, 0, 20, 3,  0};
    vecs[5] = '{2'd1, 8'h55, 5,  2, 5,  4,  8'h55};
    vecs[6] = '{2'd1, 8'hc0, 16, 0, 16, 15, 8'hc0};
    vecs[7] = '{2'd2, 8'h00, 9,  1, 9,  8,  3};
    vecs[8] = '{2'd3, 8'h03, 48, 0, 48, 15, 0};

    // Reset state
    #1;
    chk("rst ready", cmd_ready, 0);
    chk("rst strobe", write_char_strobe, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pos", write_char_pos, 0);
    chk("rst char", write_char, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst held ready", cmd_ready, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post-rst ready", cmd_ready, 1);

    // Table
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].mode, vecs[i].chr, vecs[i].stop_n, vecs[i].stop_ph, 1'b0, n, lp, lc, dt);
      chk($sformatf("vec%0d writes", i), n, vecs[i].exp_n);
      chk($sformatf("vec%0d last pos", i), lp, vecs[i].exp_pos);
      chk($sformatf("vec%0d last char", i), lc, vecs[i].exp_char);
      if (i == 0) chk("full fill accept-to-done", dt, 15 * P + 2);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d done pulse width", i), done, 0);
    end

    // stop while idle has no effect
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("idle stop busy", busy, 0);
      chk("idle stop done", done, 0);
      chk("idle stop ready", cmd_ready, 1);
    end
    stop = 1'b0;

    // Command held during busy is taken the cycle ready rises; payload changes are ignored
    hold_en = 1'b1; hold_mode = 2'd1; hold_char = 8'h2a;
    run_cmd(2'd1, 8'h11, 0, 0, 1'b0, n, lp, lc, dt);
    chk("held first last char", lc, 8'h11);
    hold_en = 1'b0;
    run_cmd(2'd1, 8'h2a, 0, 0, 1'b1, n, lp, lc, dt);
    chk("held second last char", lc, 8'h2a);

    // Reset in mid-command
    cmd_mode = 2'd1; cmd_char = 8'h66; cmd_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 100 && cmd_ready !== 1'b1; k++) begin
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(posedge CLK); #1;
      if (write_char_strobe === 1'b1 && write_char_pos === 4'd7) found = 1;
    end
    chk("mid-rst reached cell 7", found, 1);
    RST_N = 1'b0;
    #1;
    chk("mid-rst strobe", write_char_strobe, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst ready", cmd_ready, 0);
    chk("mid-rst done", done, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("mid-rst held done", done, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("mid-rst release ready", cmd_ready, 1);
    chk("mid-rst release done", done, 0);
    run_cmd(2'd1, 8'h5a, 0, 0, 1'b0, n, lp, lc, dt);
    chk("post-rst fill writes", n, 16);

    // Randomized commands against the reference
    for (int i = 0; i < 8; i++) begin
      rm = 2'($urandom_range(0, 3));
      rc = 8'($urandom_range(0, 255));
      rp = $urandom_range(0, 2);
      if (rm == 2'd3) rs = $urandom_range(1, 50);
      else rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 16) : 0;
      run_cmd(rm, rc, rs, rp, 1'b0, n, lp, lc, dt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
